// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared types and constants for the bus arbiter slice:
//               FSM state encoding, default sizing and the bus data width.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

  localparam int BUS_W               = 32;
  localparam int DEFAULT_NUM_MASTERS = 2;
  localparam int DEFAULT_MAX_HOLD    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  // Width of an index able to address n masters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_rr_pick
// Description : Combinational winner selection. Default build scans the
//               request vector round-robin starting one past last_i.
//               With RISKOW_ARB_FIXED_PRIO_EN defined, the lowest requesting
//               index wins and last_i is not used.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
  parameter int IDXW        = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDXW-1:0]        last_i,
  output logic [NUM_MASTERS-1:0] winner_o,
  output logic                   valid_o
);

  logic            found;
  logic [IDXW-1:0] idx;

`ifdef RISKOW_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;

  // Fixed priority: first requester from index 0 upward takes the bus.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = IDXW'(i);
      if (!found && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end
`else
  // Round-robin: scan last_i+1, last_i+2, ... wrapping, so last_i is checked last.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      idx = IDXW'((int'(last_i) + off) % NUM_MASTERS);
      if (!found && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end
`endif

  assign valid_o = |req_i;

endmodule : bus_arbiter_rr_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Shares one memory bus among NUM_MASTERS requesters. One
//               transfer in flight at a time (IDLE -> ACCESS -> DONE).
//               Round-robin arbitration with an optional per-master lock,
//               capped at MAX_HOLD consecutive grants.
//               Build option RISKOW_ARB_FIXED_PRIO_EN selects fixed priority
//               (lowest index wins) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
  parameter int MAX_HOLD    = DEFAULT_MAX_HOLD
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_MASTERS-1:0]       masterReq,
  input  logic [NUM_MASTERS-1:0]       masterWe,
  input  logic [BUS_W*NUM_MASTERS-1:0] masterAddr,
  input  logic [BUS_W*NUM_MASTERS-1:0] masterData,
  input  logic [NUM_MASTERS-1:0]       masterLock,
  output logic [NUM_MASTERS-1:0]       masterAck,
  output logic [BUS_W-1:0]             masterDataIn,
  output logic [NUM_MASTERS-1:0]       grant,
  output logic [BUS_W-1:0]             busAddress,
  output logic [BUS_W-1:0]             busDataOut,
  output logic                         busWriteEnable,
  input  logic [BUS_W-1:0]             busDataIn,
  input  logic                         busReady
);

  localparam int              IDXW     = idx_width(NUM_MASTERS);
  localparam int              HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0]   HOLD_ONE = HW'(1);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_MASTERS - 1);

  // Registered state
  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [NUM_MASTERS-1:0] ack_q;
  logic [BUS_W-1:0]       data_in_q;
  logic [BUS_W-1:0]       addr_q;
  logic [BUS_W-1:0]       wdata_q;
  logic                   we_q;
  logic [IDXW-1:0]        idx_q;
  logic [IDXW-1:0]        last_q;
  logic [HW-1:0]          hold_q;

  // Arbitration results for the current IDLE cycle
  logic [NUM_MASTERS-1:0] rr_winner;
  logic                   rr_valid;
  logic [NUM_MASTERS-1:0] last_vec_d;
  logic                   lock_ok_d;
  logic [NUM_MASTERS-1:0] winner_d;
  logic [IDXW-1:0]        win_idx_d;
  logic [BUS_W-1:0]       addr_d;
  logic [BUS_W-1:0]       wdata_d;
  logic                   we_d;

  bus_arbiter_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDXW        (IDXW)
  ) u_pick (
    .req_i    (masterReq),
    .last_i   (last_q),
    .winner_o (rr_winner),
    .valid_o  (rr_valid)
  );

  // Lock override: the previous owner keeps the bus while it still requests, locks and is under the cap.
  always_comb begin
    last_vec_d = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      last_vec_d[i] = (last_q == IDXW'(i));
    end
    lock_ok_d = masterReq[last_q] & masterLock[last_q] & (hold_q < HOLD_MAX);
    winner_d  = lock_ok_d ? last_vec_d : rr_winner;
  end

  // Mux the winning master's index and transfer attributes from the one-hot winner.
  always_comb begin
    win_idx_d = '0;
    addr_d    = '0;
    wdata_d   = '0;
    we_d      = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (winner_d[i]) begin
        win_idx_d = IDXW'(i);
        addr_d    = masterAddr[i*BUS_W +: BUS_W];
        wdata_d   = masterData[i*BUS_W +: BUS_W];
        we_d      = masterWe[i];
      end
    end
  end

  // Transfer FSM; every bus-facing output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      data_in_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      last_q    <= LAST_RST;
      hold_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= '0;
          if (rr_valid) begin
            grant_q <= winner_d;
            idx_q   <= win_idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            if (!lock_ok_d) begin
              hold_q <= '0;
            end
            state_q <= ST_ACCESS;
          end else begin
            we_q <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (busReady) begin
            data_in_q <= busDataIn;
            ack_q     <= grant_q;
            we_q      <= 1'b0;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          ack_q   <= '0;
          last_q  <= idx_q;
          hold_q  <= (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign masterAck      = ack_q;
  assign masterDataIn   = data_in_q;
  assign grant          = grant_q;
  assign busAddress     = addr_q;
  assign busDataOut     = wdata_q;
  assign busWriteEnable = we_q;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter. A transaction-level
//               model (last owner index, hold count, arbitration rules in
//               plain arithmetic) predicts every grant, bus value and ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int NM = 2;
  localparam int MH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NM-1:0]   masterReq = '0;
  logic [NM-1:0]   masterWe = '0;
  logic [32*NM-1:0] masterAddr = '0;
  logic [32*NM-1:0] masterData = '0;
  logic [NM-1:0]   masterLock = '0;
  logic [NM-1:0]   masterAck;
  logic [31:0]     masterDataIn;
  logic [NM-1:0]   grant;
  logic [31:0]     busAddress;
  logic [31:0]     busDataOut;
  logic            busWriteEnable;
  logic [31:0]     busDataIn = '0;
  logic            busReady = 1'b0;

  int total = 0;
  int bad   = 0;
  int m_last;
  int m_hold;

  bus_arbiter #(
    .NUM_MASTERS (NM),
    .MAX_HOLD    (MH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .masterReq      (masterReq),
    .masterWe       (masterWe),
    .masterAddr     (masterAddr),
    .masterData     (masterData),
    .masterLock     (masterLock),
    .masterAck      (masterAck),
    .masterDataIn   (masterDataIn),
    .grant          (grant),
    .busAddress     (busAddress),
    .busDataOut     (busDataOut),
    .busWriteEnable (busWriteEnable),
    .busDataIn      (busDataIn),
    .busReady       (busReady)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: lock honoured under the cap, otherwise scan order.
  task automatic pick(output int w, output bit lp);
    w  = -1;
    lp = 1'b0;
    if (masterReq[m_last] && masterLock[m_last] && m_hold < MH) begin
      w  = m_last;
      lp = 1'b1;
    end else begin
`ifdef RISKOW_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NM; i++) if (w < 0 && masterReq[i]) w = i;
`else
      for (int off = 1; off <= NM; off++) begin
        int k;
        k = (m_last + off) % NM;
        if (w < 0 && masterReq[k]) w = k;
      end
`endif
    end
  endtask

  // Called at the falling edge of an IDLE cycle with requests already driven.
  task automatic run_txn(input int delay, input logic [31:0] rdata, input bit drop_req);
    int          w;
    bit          lp;
    logic [31:0] ea, ed;
    logic        ewe;
    logic [NM-1:0] eg;
    if (masterReq == '0) masterReq[0] = 1'b1;
    pick(w, lp);
    ea  = masterAddr[32*w +: 32];
    ed  = masterData[32*w +: 32];
    ewe = masterWe[w];
    eg  = '0;
    eg[w] = 1'b1;
    for (int c = 1; c <= delay; c++) begin
      @(negedge clk);
      chk("access_grant", 32'(grant), 32'(eg));
      chk("access_addr", busAddress, ea);
      chk("access_wdata", busDataOut, ed);
      chk("access_we", 32'(busWriteEnable), 32'(ewe));
      chk("access_ack_quiet", 32'(masterAck), 32'd0);
      masterAddr[32*w +: 32] = $urandom;
      masterData[32*w +: 32] = $urandom;
      if (drop_req) masterReq[w] = 1'b0;
      busReady  = (c == delay);
      busDataIn = (c == delay) ? rdata : $urandom;
    end
    @(negedge clk);
    chk("done_ack", 32'(masterAck), 32'(eg));
    chk("done_rdata", masterDataIn, rdata);
    chk("done_we", 32'(busWriteEnable), 32'd0);
    chk("done_grant", 32'(grant), 32'(eg));
    busReady  = 1'($urandom);
    busDataIn = $urandom;
    m_last = w;
    m_hold = lp ? ((m_hold + 1 > MH) ? MH : m_hold + 1) : 1;
    @(negedge clk);
    chk("idle_ack", 32'(masterAck), 32'd0);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_we", 32'(busWriteEnable), 32'd0);
    busReady = 1'($urandom);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(masterAck), 32'd0);
    chk("rst_rdata", masterDataIn, 32'd0);
    chk("rst_addr", busAddress, 32'd0);
    chk("rst_wdata", busDataOut, 32'd0);
    chk("rst_we", 32'(busWriteEnable), 32'd0);
    reset  = 1'b1;
    m_last = NM - 1;
    m_hold = 0;

    // Single read from m0
    masterReq = 2'b01;
    masterWe  = 2'b00;
    masterAddr[31:0] = 32'h0000_0100;
    run_txn(3, 32'hDEAD_BEEF, 1'b0);

    // Contention without lock
    masterLock = 2'b00;
    for (int t = 0; t < 4; t++) begin
      masterReq = 2'b11;
      run_txn(1, $urandom, 1'b0);
    end

    // Lock cap on m1 with m0 competing
    masterLock = 2'b10;
    for (int t = 0; t < 7; t++) begin
      masterReq = 2'b11;
      run_txn(1, $urandom, 1'b0);
    end

    // Long write from m1, then idle bus holds its values with no write
    masterLock = 2'b00;
    masterReq  = 2'b10;
    masterWe   = 2'b10;
    masterAddr[63:32] = 32'h0000_0200;
    masterData[63:32] = 32'h1234_5678;
    run_txn(5, $urandom, 1'b0);
    masterReq = 2'b00;
    busReady  = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("idle_hold_grant", 32'(grant), 32'd0);
      chk("idle_hold_we", 32'(busWriteEnable), 32'd0);
      chk("idle_hold_ack", 32'(masterAck), 32'd0);
      chk("idle_hold_addr", busAddress, 32'h0000_0200);
    end
    busReady = 1'b0;

    // Reset in the second ACCESS cycle of a write
    masterReq = 2'b10;
    masterWe  = 2'b10;
    masterAddr[63:32] = 32'h0000_0300;
    masterData[63:32] = 32'hA5A5_5A5A;
    @(negedge clk);
    chk("pre_rst_we", 32'(busWriteEnable), 32'd1);
    chk("pre_rst_grant", 32'(grant), 32'd2);
    @(negedge clk);
    chk("pre_rst_we2", 32'(busWriteEnable), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", 32'(busWriteEnable), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_ack", 32'(masterAck), 32'd0);
    @(negedge clk);
    chk("mid_rst_ack2", 32'(masterAck), 32'd0);
    reset     = 1'b1;
    m_last    = NM - 1;
    m_hold    = 0;
    masterReq = 2'b11;
    masterWe  = 2'b00;
    run_txn(2, $urandom, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      masterReq  = NM'($urandom_range(1, (1 << NM) - 1));
      masterLock = NM'($urandom);
      masterWe   = NM'($urandom);
      for (int i = 0; i < NM; i++) begin
        masterAddr[32*i +: 32] = $urandom;
        masterData[32*i +: 32] = $urandom;
      end
      run_txn($urandom_range(1, 4), $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bus_arbiter
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single CPU-style memory bus (address, dataOut, dataIn, write-enable) between NUM_MASTERS requesters, e.g. the CPU core and a DMA/loader engine.
- Round-robin arbitration with optional per-master lock for back-to-back transfers, bounded by MAX_HOLD.
- Sits between the masters and the memory/peripheral decoder; one transaction in flight at a time.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- MAX_HOLD, 4, max consecutive grants to one locking master before forced rotation (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- masterReq  in  NUM_MASTERS  per-master request; held until its ack.
- masterWe  in  NUM_MASTERS  per-master write (1) / read (0).
- masterAddr  in  32*NUM_MASTERS  per-master address, master i at bits [32i+31:32i].
- masterData  in  32*NUM_MASTERS  per-master write data, same packing.
- masterLock  in  NUM_MASTERS  request to keep bus after current transfer.
- masterAck  out  NUM_MASTERS  one-cycle completion pulse, one-hot or zero.
- masterDataIn  out  32  read data; valid in the ack cycle.
- grant  out  NUM_MASTERS  one-hot owner of the in-flight transfer; zero when idle.
- busAddress  out  32  bus address.
- busDataOut  out  32  bus write data.
- busWriteEnable  out  1  1 => WRITE, 0 => READ.
- busDataIn  in  32  bus read data.
- busReady  in  1  slave completion; may be high in the first ACCESS cycle.

Behaviour:
- Reset (reset=0, async): state IDLE, grant=0, masterAck=0, masterDataIn=0, busAddress=0, busDataOut=0, busWriteEnable=0, lastGrant=NUM_MASTERS-1, holdCount=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, with any masterReq set: pick winner w.
  - If lastGrant has req and lock set, and holdCount<MAX_HOLD: w=lastGrant.
  - Otherwise w=first requester scanning lastGrant+1 upward with wrap; holdCount resets to 0.
  - Register grant, busAddress, busDataOut, busWriteEnable from w; go to ACCESS.
- IDLE, no requests: stay; all bus outputs hold, busWriteEnable=0.
- ACCESS: hold bus outputs stable. On busReady=1, capture busDataIn into masterDataIn, pulse masterAck[w] for the next cycle, clear busWriteEnable, go to DONE.
- DONE: masterAck[w]=1 this cycle only. Set lastGrant=w and holdCount=holdCount+1 (saturating), clear grant, go to IDLE.
- Latency: request sampled in IDLE at cycle 0; bus driven cycle 1; busReady at cycle k>=1; ack at cycle k+1; next arbitration at cycle k+2. Minimum 3 cycles per transfer.
- A write is asserted on busWriteEnable for exactly the ACCESS cycles.
- Dropping req during ACCESS does not abort the transfer; ack still pulses.
- masterAddr/masterData changes after grant are ignored because the values are latched.
- Simultaneous requests are resolved strictly by round-robin order; there is no starvation because lock is capped at MAX_HOLD grants.
- A lock is honoured only if the locking master re-requests in the IDLE cycle after DONE.
- busReady outside ACCESS is ignored.
- Reset asserted mid-transfer aborts immediately; no ack is issued.

Optional Feature:
- Macro RISKOW_ARB_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority, lowest index wins; lock and MAX_HOLD still apply.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package: state enum (IDLE/ACCESS/DONE), constants for default NUM_MASTERS, MAX_HOLD, bus width 32.
- Sub-module rr_pick: combinational. Inputs req vector and lastGrant; outputs one-hot winner and valid. The fixed-priority variant lives inside it under the macro.

Test Plan:
- Single read: m0 req, addr 0x100, busReady at cycle 3, busDataIn 0xDEADBEEF -> busAddress 0x100 from cycle 1, masterAck[0] at cycle 4, masterDataIn=0xDEADBEEF.
- Contention: m0 and m1 request continuously, no lock, busReady always 1 -> grants alternate m0,m1,m0,m1; acks at cycles 2,5,8,11.
- Lock cap: m1 lock=1 with continuous requests, m0 requesting, MAX_HOLD=4 -> m1 gets 4 consecutive grants, then m0 is granted.
- Write: m1 we=1, addr 0x200, data 0x12345678, busReady delayed 5 cycles -> busWriteEnable=1 for exactly 5 cycles with stable addr/data; single ack; no second bus write.
- Reset mid-ACCESS: reset low in cycle 2 of a write -> busWriteEnable=0, grant=0, no ack. After release, m0 wins first.
- With RISKOW_ARB_FIXED_PRIO_EN: m0 and m1 requesting continuously, no lock -> m0 always granted, m1 never granted until m0 req drops.
